// File: rtl/piso32_pkg.sv
// Shared types and constants for the piso32 serial transmitter.
package piso32_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/piso32_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready
// handshake and emits it one bit per shift_en strobe with framing flags.
module piso32_tx
  import piso32_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             sdo_first,
  output logic             sdo_last,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  tx_state_t        state, state_n;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic             first_q;
  logic             done_q;
  logic             last_bit;
  logic             accept;
  logic             out_bit;

  assign last_bit = (state == TX_SHIFT) && (bit_cnt == '0);
  assign accept   = in_valid && in_ready;
  assign out_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

  // Ready opens in the last-bit cycle only when that bit is being consumed,
  // which lets the next word load with no idle bubble.
  always_comb begin
    in_ready = 1'b0;
    state_n  = state;
    if (!rst) begin
      in_ready = (state == TX_IDLE) || (last_bit && shift_en);
    end
    case (state)
      TX_IDLE:  if (accept) state_n = TX_SHIFT;
      TX_SHIFT: if (last_bit && shift_en) state_n = accept ? TX_SHIFT : TX_IDLE;
      default:  state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= last_bit && shift_en;
      if (accept) begin
        sreg    <= in_data;
        bit_cnt <= CNT_TOP;
        first_q <= 1'b1;
      end else if ((state == TX_SHIFT) && shift_en) begin
        first_q <= 1'b0;
        if (bit_cnt != '0) begin
          sreg    <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
          bit_cnt <= bit_cnt - CW'(1);
        end
      end
    end
  end

  assign sdo       = (state == TX_SHIFT) && out_bit;
  assign sdo_valid = (state == TX_SHIFT);
  assign sdo_first = (state == TX_SHIFT) && first_q;
  assign sdo_last  = last_bit;
  assign done      = done_q;

endmodule

// File: tb/tb_piso32_tx.sv
// Directed bench for piso32_tx with a bit-level scoreboard model.
module tb_piso32_tx;
  import piso32_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, shift_en;
  logic [W-1:0] in_data;
  logic         sdo, sdo_valid, sdo_first, sdo_last, done;

  logic         l_in_valid, l_in_ready, l_shift_en;
  logic [W-1:0] l_in_data;
  logic         l_sdo, l_sdo_valid, l_sdo_first, l_sdo_last, l_done;

  always #5 clk = ~clk;

  piso32_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .shift_en(shift_en), .sdo(sdo), .sdo_valid(sdo_valid),
    .sdo_first(sdo_first), .sdo_last(sdo_last), .done(done)
  );

  piso32_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_data(l_in_data), .shift_en(l_shift_en), .sdo(l_sdo), .sdo_valid(l_sdo_valid),
    .sdo_first(l_sdo_first), .sdo_last(l_sdo_last), .done(l_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit bitq[$];
  int bit_idx = 0;
  bit done_exp = 1'b0;
  bit last_hs = 1'b0;
  int hs_cyc = 0;
  int done_cycs[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of the main DUT: compare against the model at the falling
  // edge, then advance the model with the inputs held for this cycle.
  task automatic cycle();
    bit ev, er, consume;
    @(negedge clk);
    last_hs = 1'b0;
    if (rst) begin
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_sdo_valid", sdo_valid, 1'b0);
      chk("rst_sdo", sdo, 1'b0);
      chk("rst_sdo_first", sdo_first, 1'b0);
      chk("rst_sdo_last", sdo_last, 1'b0);
      chk("rst_done", done, 1'b0);
      bitq.delete();
      bit_idx  = 0;
      done_exp = 1'b0;
    end else begin
      ev = (bitq.size() > 0);
      er = !ev || ((bit_idx == W-1) && shift_en);
      chk("in_ready", in_ready, er);
      chk("sdo_valid", sdo_valid, ev);
      chk("sdo", sdo, ev ? bitq[0] : 1'b0);
      chk("sdo_first", sdo_first, ev && (bit_idx == 0));
      chk("sdo_last", sdo_last, ev && (bit_idx == W-1));
      chk("done", done, done_exp);
      if (done) done_cycs.push_back(cyc);
      consume  = ev && shift_en;
      done_exp = consume && (bit_idx == W-1);
      if (consume) begin
        void'(bitq.pop_front());
        bit_idx = (bit_idx == W-1) ? 0 : bit_idx + 1;
      end
      if (in_valid && er) begin
        for (int i = W-1; i >= 0; i--) bitq.push_back(in_data[i]);
        last_hs = 1'b1;
        hs_cyc  = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] w, input int max_cyc);
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < max_cyc; n++) begin
      cycle();
      if (last_hs) break;
    end
    in_valid = 1'b0;
    if (!last_hs) chk("hs_timeout", last_hs, 1'b1);
  endtask

  task automatic wait_dones(input int cnt, input int max_cyc);
    for (int n = 0; n < max_cyc && done_cycs.size() < cnt; n++) cycle();
    chk_int("done_count", done_cycs.size(), cnt);
  endtask

  initial begin
    int c1, c2, nd;
    logic [W-1:0] lw;
    rst = 1'b0; in_valid = 1'b0; shift_en = 1'b0; in_data = '0;
    l_in_valid = 1'b0; l_shift_en = 1'b0; l_in_data = '0;

    // Reset and idle
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ready", in_ready, 1'b0);
    chk("rst_async_valid", sdo_valid, 1'b0);
    chk("rst_async_done", done, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    shift_en = 1'b1;
    repeat (3) cycle();

    // Single word, strobe every cycle
    done_cycs.delete();
    send(32'hA5A5_00FF, 5);
    c1 = hs_cyc;
    wait_dones(1, 40);
    if (done_cycs.size() == 1) chk_int("single_done_lat", done_cycs[0] - c1, W + 1);

    // Back-to-back words
    done_cycs.delete();
    send(32'h8000_0001, 5);
    c1 = hs_cyc;
    send(32'hFFFF_0000, 40);
    c2 = hs_cyc;
    chk_int("b2b_hs_gap", c2 - c1, W);
    wait_dones(2, 40);
    if (done_cycs.size() == 2) chk_int("b2b_done_gap", done_cycs[1] - done_cycs[0], W);

    // Strobe gaps: each bit held three cycles
    done_cycs.delete();
    shift_en = 1'b0;
    send(32'h0000_0003, 5);
    c1 = hs_cyc;
    for (int ph = 1; ph < 200 && done_cycs.size() == 0; ph++) begin
      shift_en = (ph % 3 == 0);
      cycle();
    end
    chk_int("gap_done_seen", done_cycs.size(), 1);
    if (done_cycs.size() == 1) chk_int("gap_done_lat", done_cycs[0] - c1, 3 * W + 1);
    shift_en = 1'b1;
    cycle();

    // LSB-first instance
    foreach (lw[i]) lw[i] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      lw = (k == 0) ? 32'h0000_0001 : 32'h1234_5678;
      l_in_valid = 1'b1;
      l_in_data  = lw;
      l_shift_en = 1'b1;
      @(negedge clk);
      chk("lsb_ready", l_in_ready, 1'b1);
      @(posedge clk);
      #1;
      l_in_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        chk("lsb_valid", l_sdo_valid, 1'b1);
        chk("lsb_sdo", l_sdo, lw[i]);
        chk("lsb_first", l_sdo_first, i == 0);
        chk("lsb_last", l_sdo_last, i == W-1);
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      chk("lsb_done", l_done, 1'b1);
      chk("lsb_idle", l_sdo_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    l_shift_en = 1'b0;

    // Reset mid-word, then a clean word
    nd = done_cycs.size();
    send(32'hDEAD_BEEF, 5);
    repeat (10) cycle();
    rst = 1'b1;
    #1;
    chk("midrst_valid", sdo_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_first", sdo_first, 1'b0);
    chk("midrst_last", sdo_last, 1'b0);
    chk("midrst_sdo", sdo, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk_int("midrst_no_done", done_cycs.size(), nd);
    send(32'h3C5A_96E1, 5);
    c1 = hs_cyc;
    wait_dones(nd + 1, 40);
    if (done_cycs.size() == nd + 1) chk_int("post_rst_done_lat", done_cycs[nd] - c1, W + 1);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
